// File: rtl/multi_edge_sync.sv
// -----------------------------------------------------------------------------
// multi_edge_sync
//
// Multi-channel asynchronous-input synchronizer with per-channel edge detect,
// one-cycle event pulse, sticky event flag and saturating event counter.
//
// Parameters
//   CH     number of independent input channels (1..32)
//   SYNC   synchronizer flop stages per channel (2..4)
//   CNT_W  event counter width per channel (1..16)
//
// Ports
//   clk       sole clock, all flops on its rising edge
//   rst       synchronous active-high reset
//   din       [CH]        asynchronous level inputs
//   mode      [2*CH]      per channel {fall_en, rise_en}: 00 off, 01 rise,
//                         10 fall, 11 both
//   clr       [CH]        per-channel synchronous clear of sticky and cnt
//   sync_out  [CH]        synchronized level of din
//   pulse     [CH]        registered one-cycle event pulse
//   sticky    [CH]        latched event flag, held until clr
//   cnt       [CH*CNT_W]  channel i count at [CNT_W*(i+1)-1 : CNT_W*i]
// -----------------------------------------------------------------------------
module multi_edge_sync #(
  parameter int CH    = 4,
  parameter int SYNC  = 2,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       din,
  input  logic [2*CH-1:0]     mode,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       sync_out,
  output logic [CH-1:0]       pulse,
  output logic [CH-1:0]       sticky,
  output logic [CH*CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    // s[0] captures din; s[SYNC-1] is the fully synchronized level.
    logic [SYNC-1:0]  s;
    logic             prev;
    logic             pulse_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise;
    logic             fall;
    logic             evt;

    assign rise = s[SYNC-1] & ~prev;
    assign fall = ~s[SYNC-1] & prev;
    // mode is used live so the value present at the evaluating edge applies.
    assign evt  = (rise & mode[2*i]) | (fall & mode[2*i+1]);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the sync chain.
    always_ff @(posedge clk) begin
      if (rst) begin
        s        <= '0;
        prev     <= 1'b0;
        pulse_q  <= 1'b0;
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        s       <= {s[SYNC-2:0], din[i]};
        // prev tracks the synchronized level regardless of mode, so enabling
        // a channel later never produces a stale edge.
        prev    <= s[SYNC-1];
        pulse_q <= evt;
        if (clr[i]) begin
          // An event coinciding with clear wins for sticky and seeds cnt at 1.
          sticky_q <= evt;
          cnt_q    <= evt ? CNT_ONE : '0;
        end else if (evt) begin
          sticky_q <= 1'b1;
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
      end
    end

    assign sync_out[i]              = s[SYNC-1];
    assign pulse[i]                 = pulse_q;
    assign sticky[i]                = sticky_q;
    assign cnt[CNT_W*i +: CNT_W]    = cnt_q;
  end

endmodule
